// File: rtl/nn_activation_unit.sv
// Activation post-processor for the MAC array: bias, rounding shift, ReLU, int8 saturation, packing.
// Optional per-lane bias input enabled by defining NN_ACT_BIAS_EN.
module nn_activation_unit #(
   parameter int unsigned LANES = 4,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [4:0]               cfg_shift,
   input  logic                     cfg_relu,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*ACC_W-1:0]   in_vector,
`ifdef NN_ACT_BIAS_EN
   input  logic [LANES*ACC_W-1:0]   in_bias,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   out_data,
   output logic [LANES-1:0]         out_sat,
   output logic [CNT_W-1:0]         sat_count,
   input  logic                     sat_clear
);

   // Two guard bits keep sum plus rounding term free of wrap for any shift.
   localparam int unsigned SUM_W  = ACC_W + 2;
   localparam int unsigned POP_W  = $clog2(LANES + 1);
   localparam int unsigned CNT_XW = CNT_W + 1;
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((64'(1) << (OUT_W - 1)) - 64'(1));
   localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

   logic                      w_in_xfer;
   logic                      w_s2_load;
   logic                      r_s1_valid;
   logic                      r_s1_relu;
   logic                      r_s2_valid;
   logic signed [SUM_W-1:0]   w_round;
   logic [LANES*OUT_W-1:0]    w_s2_data;
   logic [LANES-1:0]          w_s2_sat;
   logic [LANES*OUT_W-1:0]    r_out_data;
   logic [LANES-1:0]          r_out_sat;
   logic [POP_W-1:0]          w_pop;
   logic [CNT_XW-1:0]         w_cnt_sum;
   logic [CNT_W-1:0]          w_cnt_next;
   logic [CNT_W-1:0]          r_sat_count;

   // Handshake: S1 drains into S2 whenever S2 is empty or is being consumed.
   assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready  = !r_s1_valid || w_s2_load;
   assign w_in_xfer = in_valid && in_ready;

   assign w_round = (cfg_shift == 5'd0) ? '0 : (SUM_W'(1) << (cfg_shift - 5'd1));

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic signed [ACC_W-1:0] w_acc;
      logic signed [ACC_W-1:0] w_bias;
      logic signed [SUM_W-1:0] w_sum;
      logic signed [SUM_W-1:0] w_shr;
      logic signed [SUM_W-1:0] r_val;
      logic [OUT_W-1:0]        w_res;
      logic                    w_sat;

      assign w_acc = in_vector[g*ACC_W +: ACC_W];
`ifdef NN_ACT_BIAS_EN
      assign w_bias = in_bias[g*ACC_W +: ACC_W];
`else
      assign w_bias = '0;
`endif
      assign w_sum = SUM_W'(w_acc) + SUM_W'(w_bias) + w_round;
      assign w_shr = w_sum >>> cfg_shift;

      always_ff @(posedge clock) begin
         if (reset) begin
            r_val <= '0;
         end else if (w_in_xfer) begin
            r_val <= w_shr;
         end
      end

      // ReLU zeroing is not a clip; only the range clamps raise the flag.
      always_comb begin
         w_res = '0;
         w_sat = 1'b0;
         if (r_s1_relu && r_val[SUM_W-1]) begin
            w_res = '0;
         end else if (r_val > MAX_V) begin
            w_res = OUT_W'(MAX_V);
            w_sat = 1'b1;
         end else if (r_val < MIN_V) begin
            w_res = OUT_W'(MIN_V);
            w_sat = 1'b1;
         end else begin
            w_res = OUT_W'(r_val);
         end
      end

      assign w_s2_data[g*OUT_W +: OUT_W] = w_res;
      assign w_s2_sat[g]                 = w_sat;
   end

   // Pipeline occupancy and the ReLU mode travelling with the S1 data.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_relu  <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_relu  <= cfg_relu;
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end
         if (w_s2_load) begin
            r_s2_valid <= 1'b1;
         end else if (out_ready) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

   // Output register holds steady while the consumer stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_data <= '0;
         r_out_sat  <= '0;
      end else if (w_s2_load) begin
         r_out_data <= w_s2_data;
         r_out_sat  <= w_s2_sat;
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < LANES; i++) begin
         w_pop = w_pop + POP_W'(w_s2_sat[i]);
      end
   end

   assign w_cnt_sum  = CNT_XW'(r_sat_count) + CNT_XW'(w_pop);
   assign w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];

   // Sticky clip counter; clear wins over a same-cycle increment.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sat_count <= '0;
      end else if (sat_clear) begin
         r_sat_count <= '0;
      end else if (w_s2_load) begin
         r_sat_count <= w_cnt_next;
      end
   end

   assign out_valid = r_s2_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign sat_count = r_sat_count;

endmodule

// File: tb/tb_nn_activation_unit.sv
// Scoreboard bench for nn_activation_unit: driver queues expected results, monitor checks outputs.
module tb_nn_activation_unit;

   logic          clock = 1'b0;
   logic          reset;
   logic [4:0]    cfg_shift;
   logic          cfg_relu;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_vector;
   logic [127:0]  in_bias;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [3:0]    out_sat;
   logic [15:0]   sat_count;
   logic          sat_clear;

   always #5 clock = ~clock;

   nn_activation_unit dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vector (in_vector),
`ifdef NN_ACT_BIAS_EN
      .in_bias   (in_bias),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .sat_count (sat_count),
      .sat_clear (sat_clear)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  sat;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_cnt    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // Expected counter value once this vector has reached the output register.
   task automatic push_exp(input logic [31:0] d, input logic [3:0] s, input logic clr);
      exp_t e;
      if (clr) m_cnt = 0;
      else begin
         m_cnt = m_cnt + $countones(s);
         if (m_cnt > 65535) m_cnt = 65535;
      end
      e.data = d;
      e.sat  = s;
      e.cnt  = 16'(m_cnt);
      q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the vector is accepted.
   task automatic send(input logic [127:0] vec, input logic [127:0] bias, input logic [4:0] sh,
                       input logic relu, input logic [31:0] ed, input logic [3:0] es,
                       input logic clr);
      logic accepted;
      in_vector = vec;
      in_bias   = bias;
      cfg_shift = sh;
      cfg_relu  = relu;
      in_valid  = 1'b1;
      accepted  = 1'b0;
      for (int k = 0; k < 60 && !accepted; k++) begin
         @(negedge clock);
         if (in_ready) accepted = 1'b1;
         else begin
            @(posedge clock);
            #1;
         end
      end
      if (!accepted) begin
         n_checks++;
         $display("FAIL send_accept: vector 0x%h not accepted within 60 cycles", vec);
         in_valid = 1'b0;
      end else begin
         push_exp(ed, es, clr);
         @(posedge clock);
         #1;
         in_valid  = 1'b0;
         sat_clear = clr;
         if (clr) begin
            @(posedge clock);
            #1;
            sat_clear = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      do begin
         @(posedge clock);
         k++;
      end while (q.size() != 0 && k < 500);
      #1;
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   // Monitor: every output transfer is matched against the head of the scoreboard.
   always @(negedge clock) begin
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got data 0x%h with empty scoreboard", out_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_sat", 64'(out_sat), 64'(e.sat));
            check("sat_count", 64'(sat_count), 64'(e.cnt));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_n;
      int n_full;
      int rem;
      logic [127:0] rv;
      logic [31:0]  rd;
      logic [3:0]   rs;

      reset = 1'b1; cfg_shift = '0; cfg_relu = 1'b0; in_valid = 1'b0;
      in_vector = '0; in_bias = '0; out_ready = 1'b0; sat_clear = 1'b0;

      // Reset / idle
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_sat", 64'(out_sat), 64'd0);
      check("rst_sat_count", 64'(sat_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
      out_ready = 1'b1;

      // Rounding and packing, with latency probe
      send(pack4(32'd100, -32'd100, 32'd6, -32'd6), '0, 5'd2, 1'b0, 32'hFF02_E719, 4'b0000, 1'b0);
      @(negedge clock);
      check("latency_edge1", 64'(out_valid), 64'd0);
      @(negedge clock);
      check("latency_edge2", 64'(out_valid), 64'd1);
      @(posedge clock);
      #1;

      // Saturation, then ReLU on the same lanes
      send(pack4(32'd1000, -32'd1000, -32'd5, 32'd127), '0, 5'd0, 1'b0, 32'h7FFB_807F, 4'b0011, 1'b0);
      send(pack4(32'd1000, -32'd1000, -32'd5, 32'd127), '0, 5'd0, 1'b1, 32'h7F00_007F, 4'b0001, 1'b0);
      drain();

      // Shift-31 boundary: round term pushes past 32 bits without wrapping
      send(pack4(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h4000_0000), '0, 5'd31, 1'b0,
           32'h0100_FF01, 4'b0000, 1'b0);
      drain();

      // Backpressure stream with out_ready toggling
      fork
         begin
            for (int c = 0; c < 24; c++) begin
               out_ready = (c % 2 == 0);
               @(posedge clock);
               #1;
            end
            out_ready = 1'b0;
         end
         begin
            for (int v = 1; v <= 8; v++)
               send(pack4(32'(v), -32'(v), 32'(4 * v), 32'd200), '0, 5'd0, 1'b0,
                    {8'h7F, 8'(4 * v), 8'(-v), 8'(v)}, 4'b1000, 1'b0);
         end
      join
      repeat (5) @(posedge clock);
      #1;
      out_ready = 1'b1;
      drain();

      // Stall from empty: two accepted, then in_ready drops and output holds
      out_ready = 1'b0;
      in_vector = pack4(32'd1, 32'd2, 32'd3, 32'd4);
      cfg_shift = 5'd0;
      cfg_relu  = 1'b0;
      in_valid  = 1'b1;
      acc_n     = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (in_ready) begin
            acc_n++;
            push_exp(32'h0403_0201, 4'b0000, 1'b0);
         end
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      check("stall_accepted", 64'(acc_n), 64'd2);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_out_data", 64'(out_data), 64'h0403_0201);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      @(negedge clock);
      check("release_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
      drain();

      // Preload the counter to 0xFFFE, then saturate it
      n_full = (65534 - m_cnt) / 4;
      rem    = (65534 - m_cnt) % 4;
      for (int n = 0; n < n_full; n++)
         send(pack4(32'd1000, 32'd1000, 32'd1000, 32'd1000), '0, 5'd0, 1'b0,
              32'h7F7F_7F7F, 4'b1111, 1'b0);
      if (rem > 0) begin
         rv = '0; rd = '0; rs = '0;
         for (int i = 0; i < rem; i++) begin
            rv[i*32 +: 32] = 32'd1000;
            rd[i*8 +: 8]   = 8'h7F;
            rs[i]          = 1'b1;
         end
         send(rv, '0, 5'd0, 1'b0, rd, rs, 1'b0);
      end
      drain();
      check("preload_cnt", 64'(sat_count), 64'hFFFE);
      send(pack4(-32'd1000, -32'd1000, -32'd1000, -32'd1000), '0, 5'd0, 1'b0,
           32'h8080_8080, 4'b1111, 1'b0);
      send(pack4(32'd1000, 32'd1000, 32'd1000, 32'd1000), '0, 5'd0, 1'b0,
           32'h7F7F_7F7F, 4'b1111, 1'b0);
      drain();
      check("cnt_sticky", 64'(sat_count), 64'hFFFF);

      // Clear concurrent with a clipped vector's load
      send(pack4(32'd1000, 32'd1000, 32'd1000, 32'd1000), '0, 5'd0, 1'b0,
           32'h7F7F_7F7F, 4'b1111, 1'b1);
      send(pack4(-32'd1000, -32'd1000, -32'd1000, -32'd1000), '0, 5'd0, 1'b0,
           32'h8080_8080, 4'b1111, 1'b0);
      drain();
      check("cnt_after_clear", 64'(sat_count), 64'd4);

      // Reset with S1 and S2 both full
      out_ready = 1'b0;
      in_vector = pack4(32'd9, 32'd9, 32'd9, 32'd9);
      in_valid  = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      m_cnt     = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("midrst_out_valid", 64'(out_valid), 64'd0);
         check("midrst_in_ready", 64'(in_ready), 64'd1);
      end
      check("midrst_out_data", 64'(out_data), 64'd0);
      check("midrst_sat_count", 64'(sat_count), 64'd0);
      @(posedge clock);
      #1;

`ifdef NN_ACT_BIAS_EN
      send(pack4(-32'd10, 32'd0, 32'd5, -32'd300), pack4(32'd30, -32'd3, 32'd0, 32'd0), 5'd1, 1'b0,
           32'h8003_FF0A, 4'b1000, 1'b0);
`else
      send(pack4(-32'd10, 32'd0, 32'd5, -32'd300), '0, 5'd1, 1'b0,
           32'h8003_00FB, 4'b1000, 1'b0);
`endif
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
